compare_debounce: RTL
=====================

# compare_debounce

Sequential stage directly downstream of the 4-bit magnitude comparator. It samples the comparator's one-hot `less`/`equal`/`bigger` result on a valid strobe and commits a relation only after `DEBOUNCE` consecutive identical valid samples. It reports the committed relation, pulses on every committed change, counts changes, and flags illegal (non-one-hot) comparator codes. It feeds the control/status logic that acts on the comparison outcome.

## Interface

Parameters:
- `DEBOUNCE`, 3: consecutive identical valid samples required to commit a relation. Legal range is 1..15.
- `CNT_W`, 8: width of the change-event counter.

Ports:
- `clk`, input, 1: single clock. All state updates occur on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `in_valid`, input, 1: the comparator result is sampled on this edge.
- `less`, input, 1: comparator "in1 < in2".
- `equal`, input, 1: comparator "in1 == in2".
- `bigger`, input, 1: comparator "in1 > in2".
- `clr_err`, input, 1: synchronous clear of `onehot_err`.
- `state`, output, 2: committed relation. 00 = UNKNOWN, 01 = LESS, 10 = EQUAL, 11 = BIGGER.
- `change`, output, 1: one-cycle pulse on each committed change between known relations.
- `event_count`, output, CNT_W: count of `change` pulses, saturating.
- `onehot_err`, output, 1: sticky flag, set when an illegal code is sampled.

## Operation

**Sample classification** (only when `in_valid`=1):
- Legal codes (`less`,`equal`,`bigger`): 100 → LESS, 010 → EQUAL, 001 → BIGGER.
- Any other code (000, 110, 101, 011, 111) is illegal.

**Internal registers:**
- `cand`: 2 bits, the candidate relation.
- `run`: 4 bits, the current run length.

**Legal valid sample with code C:**
- If C == `cand` and `run` ≠ 0: `run` ← min(`run`+1, `DEBOUNCE`).
- Otherwise: `cand` ← C, `run` ← 1.
- Commit when the new `run` equals `DEBOUNCE` and `cand` ≠ `state`: `state` ← `cand`.
  - If the old `state` ≠ UNKNOWN: `change` ← 1 and `event_count` increments, saturating at 2^CNT_W−1.
  - If the old `state` = UNKNOWN (first commit): neither `change` nor `event_count` is affected.
- If the committed relation already equals the candidate, there is no action. The run stays saturated.

**Illegal valid sample:**
- `onehot_err` ← 1.
- `run` ← 0, which breaks any run. `cand` is unchanged. `state` is unchanged.

**`in_valid` = 0:**
- `cand`, `run`, `state` and `event_count` all hold. Idle cycles do not break a run.

**Error flag:**
- `clr_err`=1 clears `onehot_err`.
- If `clr_err` and an illegal sample occur in the same cycle, the set wins and `onehot_err` stays 1.

**Change pulse:**
- `change` defaults to 0 every cycle unless a commit sets it.

**FSM:** the committed state is one of UNKNOWN, LESS, EQUAL, BIGGER.
- UNKNOWN is left only by a first commit.
- There is no path back to UNKNOWN except `rst`.
- Any known state can transition to any other known state.

## Timing

- All outputs are registered. There is no combinational input-to-output path.
- Reset values:
  - `state` = 00, `change` = 0, `event_count` = 0, `onehot_err` = 0.
  - Internal: `cand` = 00, `run` = 0.
- Assertion of `rst` takes effect immediately, mid-run or at any time. The first sample after deassertion starts a new run.
- Commit latency: `state` updates on the same edge that captures the `DEBOUNCE`-th consecutive identical valid sample. `change` is high for exactly the one following cycle.
- With `DEBOUNCE`=1, every legal valid sample that differs from `state` commits on its own edge.
- Back-to-back commits: with `DEBOUNCE`=1 and alternating codes, `change` stays high on consecutive cycles and `event_count` increments every cycle.
- `onehot_err` is set on the edge that samples the illegal code.

## Test plan

Use `DEBOUNCE`=3 and `CNT_W`=8 unless stated otherwise.

1. Reset, then three valid 001 samples → after the 3rd edge `state`=11, `change` never asserted, `event_count`=0.
2. Continuing from 1: three valid 010 samples → `state`=10 after the 3rd edge, `change`=1 for exactly one cycle, `event_count`=1.
3. From EQUAL: valid 001, 001, 100, 001, 001 → `state` stays 10 and `event_count`=1. One further 001 → `state`=11, `event_count`=2.
4. Valid 100, 5 idle cycles, 100, idle, 100 → commit to `state`=01 on the 3rd valid edge. Then assert `rst` after two valid 010 samples → all outputs return to reset values immediately.
5. Valid 110 → `onehot_err`=1 and the run breaks: 100, 100 following it do not commit. Then `clr_err` → 0. Then `clr_err` together with valid 000 → `onehot_err` stays 1.
6. `DEBOUNCE`=1, `CNT_W`=2: valid 100, then alternating 010 and 001 six times → `change` high on six consecutive cycles, `event_count` saturates at 3.

Source files
------------

// File: rtl/compare_debounce_if.sv
// rtl/compare_debounce_if.sv - comparator sample and debounced status bundle
interface compare_debounce_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             less;
  logic             equal;
  logic             bigger;
  logic             clr_err;
  logic [1:0]       state;
  logic             change;
  logic [CNT_W-1:0] event_count;
  logic             onehot_err;

  modport master (
    output in_valid, less, equal, bigger, clr_err,
    input  state, change, event_count, onehot_err
  );

  modport slave (
    input  in_valid, less, equal, bigger, clr_err,
    output state, change, event_count, onehot_err
  );
endinterface

// File: rtl/compare_debounce.sv
// rtl/compare_debounce.sv - debounces one-hot comparator relations into a committed state
module compare_debounce #(
  parameter int DEBOUNCE = 3,
  parameter int CNT_W    = 8
) (
  input logic               clk,
  input logic               rst,
  compare_debounce_if.slave bus
);
  typedef enum logic [1:0] {
    UNKNOWN = 2'b00,
    LESS    = 2'b01,
    EQUAL   = 2'b10,
    BIGGER  = 2'b11
  } rel_t;

  localparam logic [3:0]       DEB     = 4'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  rel_t             cur;
  rel_t             cand;
  logic [3:0]       run;
  logic             change_q;
  logic [CNT_W-1:0] count_q;
  logic             err_q;

  rel_t       code;
  logic       legal;
  rel_t       cand_next;
  logic [3:0] run_next;

  always_comb begin
    code  = UNKNOWN;
    legal = 1'b1;
    unique case ({bus.less, bus.equal, bus.bigger})
      3'b100:  code = LESS;
      3'b010:  code = EQUAL;
      3'b001:  code = BIGGER;
      default: legal = 1'b0;
    endcase
  end

  // A zero run means the previous sample was illegal, so even a matching code restarts.
  always_comb begin
    cand_next = code;
    run_next  = 4'd1;
    if (code == cand && run != 4'd0) begin
      cand_next = cand;
      run_next  = (run >= DEB) ? DEB : run + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur      <= UNKNOWN;
      cand     <= UNKNOWN;
      run      <= 4'd0;
      change_q <= 1'b0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      change_q <= 1'b0;
      if (bus.clr_err) begin
        err_q <= 1'b0;
      end
      if (bus.in_valid) begin
        if (legal) begin
          cand <= cand_next;
          run  <= run_next;
          if (run_next == DEB && cand_next != cur) begin
            cur <= cand_next;
            if (cur != UNKNOWN) begin
              change_q <= 1'b1;
              if (count_q != CNT_MAX) begin
                count_q <= count_q + 1'b1;
              end
            end
          end
        end else begin
          err_q <= 1'b1;
          run   <= 4'd0;
        end
      end
    end
  end

  assign bus.state       = cur;
  assign bus.change      = change_q;
  assign bus.event_count = count_q;
  assign bus.onehot_err  = err_q;
endmodule
